// File: rtl/btn_repeat_ctrl.sv
`timescale 1ns/1ps
// N-channel push-button front end: 2-flop synchroniser, per-channel debounce and
// registered press/release pulses. Macro BTN_AUTOREPEAT_EN adds auto-repeat of held buttons.
module btn_repeat_ctrl #(
  parameter int NUM_BTNS        = 2,
  parameter int MIN_PULSE_WIDTH = 25000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                  i_clk,
  input  logic                  reset_n,
  input  logic [NUM_BTNS-1:0]   i_btn,
  output logic [NUM_BTNS-1:0]   o_btn,
  output logic [NUM_BTNS-1:0]   o_press,
  output logic [NUM_BTNS-1:0]   o_release,
  output logic                  o_any_press,
  output logic [2*NUM_BTNS-1:0] o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  localparam int             CNT_W    = $clog2(MIN_PULSE_WIDTH + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(MIN_PULSE_WIDTH - 1);
  localparam logic           REL_LVL  = (ACTIVE_LOW != 0);

  if (NUM_BTNS < 1 || MIN_PULSE_WIDTH < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_repeat_ctrl: all size/timing parameters must be >= 1");
  end

  logic [NUM_BTNS-1:0] sync1_q, sync2_q;
  logic [NUM_BTNS-1:0] s_w;
  logic [CNT_W-1:0]    deb_cnt_q [NUM_BTNS];
  logic [CNT_W-1:0]    deb_cnt_d [NUM_BTNS];
  logic [NUM_BTNS-1:0] btn_q, btn_d;
  logic [NUM_BTNS-1:0] rise_w, fall_w;
  logic [NUM_BTNS-1:0] press_q, press_d;
  logic [NUM_BTNS-1:0] release_q, release_d;
  logic                any_q, any_d;

  // Synchronisers idle at the released pin level so reset never looks like a press.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= {NUM_BTNS{REL_LVL}};
      sync2_q <= {NUM_BTNS{REL_LVL}};
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  assign s_w = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_comb begin
    btn_d  = btn_q;
    rise_w = '0;
    fall_w = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      deb_cnt_d[i] = '0;
      if (s_w[i] != btn_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          btn_d[i]  = s_w[i];
          rise_w[i] = s_w[i];
          fall_w[i] = ~s_w[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);

  state_e           state_q [NUM_BTNS];
  state_e           state_d [NUM_BTNS];
  logic [RPT_W-1:0] rpt_cnt_q [NUM_BTNS];
  logic [RPT_W-1:0] rpt_cnt_d [NUM_BTNS];

  // A debounced release always takes priority over a repeat expiring on the same edge.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (fall_w[i]) begin
        release_d[i] = 1'b1;
        state_d[i]   = ST_IDLE;
        rpt_cnt_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (rise_w[i]) begin
              press_d[i]   = 1'b1;
              state_d[i]   = ST_DELAY;
              rpt_cnt_d[i] = '0;
            end
          end
          ST_DELAY: begin
            if (rpt_cnt_q[i] == RD_LAST) begin
              press_d[i]   = 1'b1;
              state_d[i]   = ST_REPEAT;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt_q[i] == RP_LAST) begin
              press_d[i]   = 1'b1;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
            end
          end
          default: begin
            state_d[i]   = ST_IDLE;
            rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        state_q[i]   <= ST_IDLE;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        state_q[i]   <= state_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  always_comb begin
    o_state = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      o_state[2*i +: 2] = state_q[i];
    end
  end
`else
  // Without auto-repeat the channel has no timed states; events follow the debounced edges.
  always_comb begin
    press_d   = rise_w;
    release_d = fall_w;
  end

  assign o_state = {NUM_BTNS{ST_IDLE}};
`endif

  assign any_d = |press_d;

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
    end
  end

  assign o_btn       = btn_q;
  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_any_press = any_q;

endmodule

// File: tb/tb_btn_repeat_ctrl.sv
`timescale 1ns/1ps
// Directed bench for btn_repeat_ctrl: glitch rejection, press/repeat/release timing,
// release-vs-repeat collision, channel independence and reset during DELAY.
module tb_btn_repeat_ctrl;

  localparam int MPW = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = MPW + 1;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [1:0] btn;
  logic [1:0] o_btn, o_press, o_release;
  logic       o_any_press;
  logic [3:0] o_state;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  btn_repeat_ctrl #(
    .NUM_BTNS(2),
    .MIN_PULSE_WIDTH(MPW),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk),
    .reset_n(reset_n),
    .i_btn(btn),
    .o_btn(o_btn),
    .o_press(o_press),
    .o_release(o_release),
    .o_any_press(o_any_press),
    .o_state(o_state)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
    end
  endtask

  // Press pulse expected at step j for an initial press at step p.
  function automatic logic rep_exp(input int j, input int p);
    if (j == p) return 1'b1;
    if (AR && j >= p + RD && ((j - p - RD) % RP) == 0) return 1'b1;
    return 1'b0;
  endfunction

  // Channel c is held low from step d[c] (negative = untouched) until step hold.
  task automatic seq(input string name, input int d0, input int d1, input int hold, input int cycles);
    int d [2];
    logic [1:0] e_btn, e_press, e_rel;
    d[0] = d0;
    d[1] = d1;
    for (int j = 0; j < cycles; j++) begin
      for (int c = 0; c < 2; c++) begin
        btn[c]     = !(d[c] >= 0 && j >= d[c] && j < hold);
        e_btn[c]   = d[c] >= 0 && j >= d[c] + LAT && j < hold + LAT;
        e_press[c] = d[c] >= 0 && j < hold + LAT && rep_exp(j, d[c] + LAT);
        e_rel[c]   = d[c] >= 0 && j == hold + LAT;
      end
      tick();
      step = j;
      check({name, ".btn"}, 32'(o_btn), 32'(e_btn));
      check({name, ".press"}, 32'(o_press), 32'(e_press));
      check({name, ".release"}, 32'(o_release), 32'(e_rel));
      check({name, ".any"}, 32'(o_any_press), 32'(|e_press));
      if (d0 == 0 && j == 10) check({name, ".st_delay"}, 32'(o_state[1:0]), AR ? 32'd1 : 32'd0);
      if (d0 == 0 && j == 30) check({name, ".st_repeat"}, 32'(o_state[1:0]), AR ? 32'd2 : 32'd0);
    end
    check({name, ".st_end"}, 32'(o_state), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    btn     = 2'b11;
    #5;
    step = -1;
    check("rst.btn", 32'(o_btn), 32'd0);
    check("rst.press", 32'(o_press), 32'd0);
    check("rst.release", 32'(o_release), 32'd0);
    check("rst.any", 32'(o_any_press), 32'd0);
    check("rst.state", 32'(o_state), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int j = 0; j < 4; j++) tick();

    // Three low samples on channel 0 must be ignored.
    for (int j = 0; j < 15; j++) begin
      btn[0] = (j >= 3);
      tick();
      step = j;
      check("glitch.btn", 32'(o_btn), 32'd0);
      check("glitch.press", 32'(o_press), 32'd0);
      check("glitch.release", 32'(o_release), 32'd0);
      check("glitch.any", 32'(o_any_press), 32'd0);
    end

    // 60-cycle press: pulse at 5, repeats at 25..57; release at 65 collides with a repeat.
    seq("clean", 0, -1, 60, 70);
    for (int j = 0; j < 4; j++) tick();

    // Debounced release on the k+33 repeat edge.
    seq("collide", 0, -1, 28, 40);
    for (int j = 0; j < 4; j++) tick();

    seq("indep", 0, 2, 40, 50);
    for (int j = 0; j < 4; j++) tick();

    seq("simul", 0, 0, 26, 34);
    for (int j = 0; j < 4; j++) tick();

    // Reset while channel 0 sits in DELAY, then a fresh press with the button still held.
    for (int j = 0; j < 15; j++) begin
      btn[0] = 1'b0;
      tick();
      step = j;
    end
    check("midrst.pre_btn", 32'(o_btn), 32'd1);
    check("midrst.pre_state", 32'(o_state[1:0]), AR ? 32'd1 : 32'd0);
    reset_n = 1'b0;
    #1;
    check("midrst.btn", 32'(o_btn), 32'd0);
    check("midrst.press", 32'(o_press), 32'd0);
    check("midrst.release", 32'(o_release), 32'd0);
    check("midrst.any", 32'(o_any_press), 32'd0);
    check("midrst.state", 32'(o_state), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      step = j;
      check("rearm.btn", 32'(o_btn), (j >= LAT) ? 32'd1 : 32'd0);
      check("rearm.press", 32'(o_press), (j == LAT) ? 32'd1 : 32'd0);
      check("rearm.release", 32'(o_release), 32'd0);
    end
    btn = 2'b11;
    for (int j = 0; j < 10; j++) tick();
    check("final.btn", 32'(o_btn), 32'd0);
    check("final.state", 32'(o_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
